// File: rtl/spi_slave_mod.sv
// spi_slave_mod: SPI responder with synchronized inputs, one-deep TX buffer, RX holding register; SPI_SLAVE_OVR_DET_EN adds rx_ovr_o
module spi_slave_mod #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  sclk_i,
  input  logic                  ss_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  lsbfe_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_wr_i,
  output logic                  tx_empty_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_full_o,
  input  logic                  rx_rd_i,
  output logic                  busy_o
`ifdef SPI_SLAVE_OVR_DET_EN
  , output logic                rx_ovr_o
`endif
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [0:0] IDLE = 1'b0, ACTIVE = 1'b1;
  logic [0:0] state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_d, ss_d, cpol_q, cpha_q, lsbfe_q;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr, tx_buf, tx_src, rx_next, tx_shf, start_shf;
  logic sclk_s, ss_s, mosi_s, sclk_edge, lead, trail, ss_fall, ss_rise;
  logic start, sample, shift, done, tx_out, start_bit;
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_edge = sclk_s ^ sclk_d;
  assign lead      = sclk_edge && (sclk_s != cpol_q);
  assign trail     = sclk_edge && (sclk_s == cpol_q);
  assign ss_fall   = !ss_s && ss_d;
  assign ss_rise   = ss_s && !ss_d;
  assign busy_o    = state == ACTIVE;
  assign start     = !busy_o && ss_fall;
  assign sample    = busy_o && !ss_rise && (cpha_q ? trail : lead);
  assign shift     = busy_o && !ss_rise && (cpha_q ? lead : trail);
  assign done      = sample && (cnt == CW'(DATA_WIDTH - 1));
  assign rx_next   = lsbfe_q ? {mosi_s, rx_sr[DATA_WIDTH-1:1]} : {rx_sr[DATA_WIDTH-2:0], mosi_s};
  assign tx_src    = tx_empty_o ? '0 : tx_buf;
  assign tx_out    = lsbfe_q ? tx_sr[0] : tx_sr[DATA_WIDTH-1];
  assign tx_shf    = lsbfe_q ? tx_sr >> 1 : tx_sr << 1;
  assign start_bit = lsbfe_i ? tx_src[0] : tx_src[DATA_WIDTH-1];
  assign start_shf = lsbfe_i ? tx_src >> 1 : tx_src << 1;
  // Synchronizers plus edge-detect history; ss history resets low so a reset with ss held low does not re-arm
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end
  // Frame FSM and shift datapath; the TX register always holds the bits not yet presented on miso
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      miso_o    <= 1'b0;
      miso_oe_o <= 1'b0;
      cnt       <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsbfe_q   <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
    end else if (start) begin
      state     <= ACTIVE;
      cpol_q    <= cpol_i;
      cpha_q    <= cpha_i;
      lsbfe_q   <= lsbfe_i;
      miso_oe_o <= 1'b1;
      cnt       <= '0;
      rx_sr     <= '0;
      tx_sr     <= cpha_i ? tx_src : start_shf;
      miso_o    <= cpha_i ? 1'b0 : start_bit;
    end else if (busy_o && ss_rise) begin
      state     <= IDLE;
      miso_oe_o <= 1'b0;
      miso_o    <= 1'b0;
      cnt       <= '0;
    end else begin
      if (sample) begin
        rx_sr <= rx_next;
        cnt   <= done ? '0 : cnt + 1'b1;
        if (done) tx_sr <= tx_src;
      end
      if (shift) begin
        miso_o <= tx_out;
        tx_sr  <= tx_shf;
      end
    end
  end
  // TX buffer: a write into a free buffer wins over a same-cycle consume
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_buf     <= '0;
      tx_empty_o <= 1'b1;
    end else if (tx_wr_i && tx_empty_o) begin
      tx_buf     <= tx_data_i;
      tx_empty_o <= 1'b0;
    end else if (start || done) begin
      tx_empty_o <= 1'b1;
    end
  end
  // RX holding register; frame completion beats a same-cycle read acknowledge
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_data_o <= '0;
      rx_full_o <= 1'b0;
`ifdef SPI_SLAVE_OVR_DET_EN
      rx_ovr_o  <= 1'b0;
`endif
    end else begin
      if (done) rx_data_o <= rx_next;
      rx_full_o <= done | (rx_full_o & ~rx_rd_i);
`ifdef SPI_SLAVE_OVR_DET_EN
      rx_ovr_o  <= (done & rx_full_o) | (rx_ovr_o & ~rx_rd_i);
`endif
    end
  end
endmodule

// File: tb/tb_spi_slave_mod.sv
// tb_spi_slave_mod: directed SPI master model with an RX-frame scoreboard for spi_slave_mod
module tb_spi_slave_mod;
  localparam int H = 6;
  logic PCLK = 0, PRESET = 1, sclk = 0, ss = 1, mosi = 0;
  logic cpol = 0, cpha = 0, lsbfe = 0, tx_wr = 0, rx_rd = 0;
  logic [7:0] tx_data = 0;
  logic miso, miso_oe, tx_empty, rx_full, busy;
  logic [7:0] rx_data;
`ifdef SPI_SLAVE_OVR_DET_EN
  logic rx_ovr;
`endif
  int errors = 0, checks = 0;
  logic [7:0] exp_q[$];
  logic full_prev = 0;
  logic [7:0] r, r1, r2;

  spi_slave_mod dut (
    .PCLK(PCLK), .PRESET(PRESET), .sclk_i(sclk), .ss_i(ss), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe), .cpol_i(cpol), .cpha_i(cpha), .lsbfe_i(lsbfe),
    .tx_data_i(tx_data), .tx_wr_i(tx_wr), .tx_empty_o(tx_empty), .rx_data_o(rx_data),
    .rx_full_o(rx_full), .rx_rd_i(rx_rd), .busy_o(busy)
`ifdef SPI_SLAVE_OVR_DET_EN
    , .rx_ovr_o(rx_ovr)
`endif
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each rising rx_full presents one completed frame
  always @(negedge PCLK) begin
    if (!PRESET && rx_full && !full_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %h expected no frame", rx_data);
      end else chk("rx_frame", rx_data, exp_q.pop_front());
    end
    full_prev = rx_full;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc(int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic tx_write(logic [7:0] d);
    @(negedge PCLK) begin tx_data = d; tx_wr = 1; end
    @(negedge PCLK) tx_wr = 0;
  endtask

  task automatic rx_read();
    @(negedge PCLK) rx_rd = 1;
    @(negedge PCLK) rx_rd = 0;
  endtask

  task automatic set_mode(logic c, logic p, logic l);
    cpol = c; cpha = p; lsbfe = l; sclk = c;
    cyc(4);
  endtask

  task automatic ss_low();
    ss = 0;
    cyc(8);
  endtask

  task automatic ss_high();
    cyc(H);
    ss = 1;
    cyc(8);
  endtask

  task automatic xfer(logic [7:0] d, int nbits, output logic [7:0] rv);
    rv = 0;
    for (int k = 0; k < nbits; k++) begin
      int i = lsbfe ? k : 7 - k;
      if (!cpha) begin
        mosi = d[i];
        cyc(H);
        sclk = ~cpol;
        rv[i] = miso;
        cyc(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = d[i];
        cyc(H);
        sclk = cpol;
        rv[i] = miso;
        cyc(H);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 6; k++) begin
      sclk = ~sclk;
      cyc(2);
      chk1("reset_busy", busy, 1'b0);
    end
    chk1("reset_miso", miso, 1'b0);
    chk1("reset_oe", miso_oe, 1'b0);
    chk1("reset_tx_empty", tx_empty, 1'b1);
    chk("reset_rx_data", rx_data, 8'h00);
    chk1("reset_rx_full", rx_full, 1'b0);
    PRESET = 0;
    cyc(6);
    chk1("idle_busy", busy, 1'b0);

    set_mode(0, 1, 1);
    tx_write(8'h9F);
    chk1("txbuf_loaded", tx_empty, 1'b0);
    exp_q.push_back(8'h0F);
    ss_low();
    chk1("active_busy", busy, 1'b1);
    chk1("active_oe", miso_oe, 1'b1);
    chk1("entry_tx_empty", tx_empty, 1'b1);
    xfer(8'h0F, 8, r);
    ss_high();
    chk("m1_miso_bits", r, 8'h9F);
    chk1("end_oe", miso_oe, 1'b0);
    chk1("end_miso", miso, 1'b0);
    rx_read();
    chk1("rd_clears_full", rx_full, 1'b0);

    for (int m = 0; m < 3; m++) begin
      set_mode(m != 0, m == 2, 0);
      tx_write(8'hA5);
      exp_q.push_back(8'h3C);
      ss_low();
      xfer(8'h3C, 8, r);
      ss_high();
      chk("mode_master_rx", r, 8'hA5);
      rx_read();
    end

    set_mode(0, 0, 0);
    tx_write(8'h5A);
    exp_q.push_back(8'h11);
    ss_low();
    xfer(8'h11, 8, r1);
    xfer(8'h22, 8, r2);
    ss_high();
    chk("b2b_tx1", r1, 8'h5A);
    chk("b2b_tx2_empty", r2, 8'h00);
    chk("b2b_rx_data", rx_data, 8'h22);
    chk1("b2b_rx_full", rx_full, 1'b1);
`ifdef SPI_SLAVE_OVR_DET_EN
    chk1("b2b_ovr", rx_ovr, 1'b1);
`endif
    rx_read();
`ifdef SPI_SLAVE_OVR_DET_EN
    chk1("ovr_cleared", rx_ovr, 1'b0);
`endif

    ss_low();
    xfer(8'hFF, 5, r);
    ss_high();
    chk1("partial_busy", busy, 1'b0);
    chk1("partial_oe", miso_oe, 1'b0);
    chk1("partial_rx_full", rx_full, 1'b0);
    chk("partial_rx_data", rx_data, 8'h22);
    exp_q.push_back(8'h77);
    ss_low();
    xfer(8'h77, 8, r);
    ss_high();
    chk("after_partial_tx", r, 8'h00);
    rx_read();

    set_mode(0, 1, 0);
    tx_write(8'h66);
    ss_low();
    xfer(8'hAA, 3, r);
    PRESET = 1;
    cyc(2);
    chk1("midreset_busy", busy, 1'b0);
    chk1("midreset_oe", miso_oe, 1'b0);
    chk1("midreset_tx_empty", tx_empty, 1'b1);
    chk("midreset_rx_data", rx_data, 8'h00);
    PRESET = 0;
    xfer(8'h55, 5, r);
    chk1("no_rearm_busy", busy, 1'b0);
    ss_high();
    tx_write(8'h96);
    exp_q.push_back(8'hC3);
    ss_low();
    xfer(8'hC3, 8, r);
    ss_high();
    chk("post_reset_tx", r, 8'h96);
    rx_read();
    cyc(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_frames: got %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_slave_mod.md
# spi_slave_mod

Synchronous SPI slave (responder) for the counterpart of the APB SPI master. It sits on the far side of the `ss`/`sclk`/`mosi`/`miso` link and samples the external `sclk_i`, `ss_i` and `mosi_i` in the `PCLK` domain. It shifts received frames into an RX holding register and drives `miso_o` from a one-deep TX buffer. It supports all four CPOL/CPHA modes and both bit orders, matching the master's CR1 settings.

## Interface
- DATA_WIDTH, 8, frame length in bits; also the width of the TX and RX registers.
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on `sclk_i`, `ss_i` and `mosi_i`; minimum 2.
- PCLK  in  1  system clock; all logic is on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- sclk_i  in  1  SPI clock from the master; asynchronous to `PCLK`.
- ss_i  in  1  slave select, active low; asynchronous to `PCLK`.
- mosi_i  in  1  serial data from the master.
- miso_o  out  1  serial data to the master.
- miso_oe_o  out  1  MISO output enable; high while a frame is selected.
- cpol_i, cpha_i, lsbfe_i  in  1 each  mode bits; latched at frame start.
- tx_data_i  in  DATA_WIDTH  TX buffer write data.
- tx_wr_i  in  1  TX buffer write strobe; takes effect only when `tx_empty_o`=1.
- tx_empty_o  out  1  TX buffer free.
- rx_data_o  out  DATA_WIDTH  last completed received frame.
- rx_full_o  out  1  `rx_data_o` holds unread data.
- rx_rd_i  in  1  read acknowledge; clears `rx_full_o`.
- busy_o  out  1  high while the FSM is in ACTIVE.

## Operation
- Reset values: `miso_o`=0, `miso_oe_o`=0, `tx_empty_o`=1, `rx_data_o`=0, `rx_full_o`=0, `busy_o`=0; FSM in IDLE; bit counter = 0.
- Edge naming:
  - Leading edge: `sclk` transition away from its CPOL idle level.
  - Trailing edge: transition back to the idle level.
  - CPHA=0: sample on the leading edge, shift on the trailing edge.
  - CPHA=1: shift on the leading edge, sample on the trailing edge.
- IDLE → ACTIVE on the synchronized falling edge of `ss`. On entry:
  - latch the mode bits;
  - load the TX shift register from the TX buffer, or 0x00 if the buffer is empty;
  - set `tx_empty_o`=1;
  - clear the bit counter;
  - assert `miso_oe_o`.
- Bit presentation and ordering:
  - CPHA=0: the first bit appears on `miso_o` on entry to ACTIVE.
  - CPHA=1: the first bit appears on the first leading edge.
  - `lsbfe`=1 sends and receives bit 0 first; otherwise the MSB goes first.
- Sample edge: shift the synchronized `mosi` into the RX shift register and increment the bit counter.
- On the DATA_WIDTH-th sample:
  - copy the RX shift register to `rx_data_o`;
  - set `rx_full_o`;
  - reload the TX shift register from the buffer (0x00 if empty);
  - wrap the counter to 0.
  - If `ss` stays low, the next frame continues back-to-back.
- ACTIVE → IDLE on the synchronized `ss` rise:
  - `miso_oe_o`=0 and `miso_o`=0;
  - a partial frame is discarded; `rx_data_o` and `rx_full_o` are unchanged.
- TX buffer: `tx_wr_i` with `tx_empty_o`=1 loads the buffer and clears `tx_empty_o` on the next cycle. A write while `tx_empty_o`=0 is ignored.
- `rx_rd_i` clears `rx_full_o` next cycle. If frame completion and `rx_rd_i` land on the same cycle, completion wins and `rx_full_o` stays 1.
- A frame completing while `rx_full_o`=1 overwrites `rx_data_o`; see Configuration.
- PRESET mid-frame forces the reset values immediately. The slave re-arms only on the next `ss` falling edge.

## Timing
- Input latency: SYNC_STAGES cycles of synchronizer, plus 1 edge-detect register.
- `rx_full_o` rises SYNC_STAGES+1 `PCLK` cycles after the raw final sample edge.
- `miso_o` changes SYNC_STAGES+1 cycles after the raw shift edge. CPHA=0 first bit: SYNC_STAGES+1 cycles after the raw `ss` fall.
- Required SCLK half-period: ≥ SYNC_STAGES+2 `PCLK` cycles, i.e. ≥ 4 at the default.
- Required `ss` setup before the first `sclk` edge: ≥ SYNC_STAGES+2 `PCLK` cycles.
- `tx_empty_o` and `rx_full_o` are registered. `busy_o` is 1 exactly while in ACTIVE.

## Configuration
- SPI_SLAVE_OVR_DET_EN defined:
  - adds output `rx_ovr_o` (reset 0);
  - `rx_ovr_o` sets when a frame completes with `rx_full_o`=1;
  - `rx_ovr_o` clears on `rx_rd_i`, unless a new overrun occurs in the same cycle.
  - The completing frame still overwrites `rx_data_o`.
- SPI_SLAVE_OVR_DET_EN undefined: no `rx_ovr_o` port; overrun overwrites `rx_data_o` silently.

## Test plan
- Reset, with `ss_i`=1 and `sclk` toggling → all outputs at their reset values; `busy_o`=0 throughout.
- CPOL=0, CPHA=1, LSB first; TX buffer loaded with 0x9F; master sends 0x0F → `rx_data_o`=0x0F with `rx_full_o`=1; bits captured on MISO are 1,1,1,1,1,0,0,1 (= 0x9F).
- Modes 0/2/3, MSB first; slave TX 0xA5, master sends 0x3C → `rx_data_o`=0x3C and master receives 0xA5 in every mode.
- Two back-to-back frames (0x11, 0x22) with `ss` held low and no `rx_rd_i`:
  - `rx_data_o`=0x22;
  - `rx_ovr_o`=1 when SPI_SLAVE_OVR_DET_EN is defined;
  - second TX frame is 0x00 when the buffer was not refilled.
- `ss` raised after 5 bits → FSM returns to IDLE; `rx_full_o` stays 0; `miso_oe_o`=0; the next full frame 0x77 is received correctly.
- PRESET pulsed mid-frame, then a new frame 0xC3 → clean reset; 0xC3 is received correctly.
